bus_arbiter: RTL and testbench

Central arbiter for the serial bus: shares the single bit-serial address/data channel among `NUM_INIT` initiator ports, each of which raises `arbiter_req` and waits for `arbiter_grant`. Grants are one-hot and round-robin. Every ownership change is followed by a turnaround gap. The arbiter also tracks one outstanding split transaction: when a target splits, the bus is freed for other initiators, and the split initiator is re-granted with top priority once the target signals it is ready.

---
 rtl/bus_arb_pkg.sv | 22 ++
 rtl/bus_rr_pick.sv | 36 +++
 rtl/bus_arbiter.sv | 165 ++++++++++++++++
 tb/tb_bus_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the serial-bus arbiter and its priority picker.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OWNED   = 2'd1,
    ST_RESUMED = 2'd2,
    ST_TURN    = 2'd3
  } arb_state_e;

  localparam int MAX_INIT = 4;
  localparam int TURN_W   = 3;

  // Round-robin search origin: the initiator after `cur`, wrapping at n.
  function automatic logic [1:0] rr_next(input logic [1:0] cur, input int n);
    logic [1:0] nxt;
    if (int'(cur) + 1 >= n) nxt = 2'd0;
    else                    nxt = cur + 2'd1;
    return nxt;
  endfunction

endpackage

// File: rtl/bus_rr_pick.sv
// Combinational rotate-priority encoder: first set bit of mask_i at or after start_i, wrapping.
module bus_rr_pick #(
  parameter int N   = 2,
  parameter int IDW = 1
) (
  input  logic [N-1:0]   mask_i,
  input  logic [IDW-1:0] start_i,
  output logic [IDW-1:0] idx_o,
  output logic           valid_o
);

  localparam logic [IDW:0] NL = (IDW+1)'(N);

  logic [N-1:0]   rot;
  logic [N-1:0]   first;
  logic [IDW-1:0] acc [N+1];
  logic [IDW:0]   sum;

  // Rotating the doubled mask puts start_i at bit 0, so a plain LSB-first search suffices.
  assign rot    = N'({mask_i, mask_i} >> start_i);
  assign acc[0] = '0;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_pos
      localparam logic [N-1:0] LOWER = N'((1 << gi) - 1);
      assign first[gi]  = rot[gi] & ~|(rot & LOWER);
      assign acc[gi+1]  = acc[gi] | (first[gi] ? IDW'(gi) : '0);
    end
  endgenerate

  assign sum     = {1'b0, start_i} + {1'b0, acc[N]};
  assign idx_o   = (sum >= NL) ? IDW'(sum - NL) : IDW'(sum);
  assign valid_o = |mask_i;

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the bit-serial bus with turnaround gaps and a single split-transaction slot.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int NUM_INIT   = 2,
  parameter int TURNAROUND = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_INIT-1:0]         req,
  input  logic                        target_split,
  input  logic                        split_release,
  input  logic                        target_ack,
  output logic [NUM_INIT-1:0]         grant,
  output logic [$clog2(NUM_INIT)-1:0] owner_id,
  output logic                        bus_busy,
  output logic                        split_pending,
  output logic [$clog2(NUM_INIT)-1:0] split_id,
  output logic                        split_overflow
);

  localparam int IDW = $clog2(NUM_INIT);

  generate
    if (NUM_INIT < 2 || NUM_INIT > MAX_INIT) begin : g_bad_num_init
      $error("bus_arbiter: NUM_INIT out of range");
    end
    if (TURNAROUND < 1 || TURNAROUND > (1 << TURN_W) - 1) begin : g_bad_turnaround
      $error("bus_arbiter: TURNAROUND out of range");
    end
  endgenerate

  arb_state_e          state_q,     state_d;
  logic [NUM_INIT-1:0] grant_q,     grant_d;
  logic [IDW-1:0]      owner_q,     owner_d;
  logic                busy_q,      busy_d;
  logic                split_pnd_q, split_pnd_d;
  logic [IDW-1:0]      split_id_q,  split_id_d;
  logic                split_ovf_q, split_ovf_d;
  logic                rel_q,       rel_d;
  logic [TURN_W-1:0]   turn_cnt_q,  turn_cnt_d;

  logic [NUM_INIT-1:0] split_mask;
  logic [NUM_INIT-1:0] eligible;
  logic [IDW-1:0]      rr_start;
  logic [IDW-1:0]      pick_idx;
  logic                pick_valid;

  // The split initiator must wait for its resume grant, so it is masked out of normal arbitration.
  always_comb begin
    split_mask = '0;
    if (split_pnd_q) split_mask[split_id_q] = 1'b1;
  end

  assign eligible = req & ~split_mask;
  assign rr_start = IDW'(rr_next(2'(owner_q), NUM_INIT));

  bus_rr_pick #(
    .N   (NUM_INIT),
    .IDW (IDW)
  ) u_pick (
    .mask_i  (eligible),
    .start_i (rr_start),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    owner_d     = owner_q;
    split_pnd_d = split_pnd_q;
    split_id_d  = split_id_q;
    split_ovf_d = split_ovf_q;
    turn_cnt_d  = turn_cnt_q;
    // A release only counts against an already-occupied slot.
    rel_d       = rel_q | (split_release & split_pnd_q);

    case (state_q)
      ST_IDLE: begin
        if (split_pnd_q && rel_q) begin
          grant_d             = '0;
          grant_d[split_id_q] = 1'b1;
          owner_d             = split_id_q;
          split_pnd_d         = 1'b0;
          rel_d               = 1'b0;
          state_d             = ST_RESUMED;
        end else if (pick_valid) begin
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          owner_d           = pick_idx;
          state_d           = ST_OWNED;
        end
      end

      ST_OWNED: begin
        if (target_split) begin
          if (!split_pnd_q) begin
            split_pnd_d = 1'b1;
            split_id_d  = owner_q;
          end else begin
            split_ovf_d = 1'b1;
          end
          grant_d    = '0;
          turn_cnt_d = TURN_W'(TURNAROUND - 1);
          state_d    = ST_TURN;
        end else if (!req[owner_q]) begin
          grant_d    = '0;
          turn_cnt_d = TURN_W'(TURNAROUND - 1);
          state_d    = ST_TURN;
        end
      end

      ST_RESUMED: begin
        if (target_split) split_ovf_d = 1'b1;
        if (target_ack) begin
          grant_d    = '0;
          turn_cnt_d = TURN_W'(TURNAROUND - 1);
          state_d    = ST_TURN;
        end
      end

      ST_TURN: begin
        if (turn_cnt_q == '0) state_d    = ST_IDLE;
        else                  turn_cnt_d = turn_cnt_q - 1'b1;
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = |grant_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      owner_q     <= IDW'(NUM_INIT - 1);
      busy_q      <= 1'b0;
      split_pnd_q <= 1'b0;
      split_id_q  <= '0;
      split_ovf_q <= 1'b0;
      rel_q       <= 1'b0;
      turn_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      owner_q     <= owner_d;
      busy_q      <= busy_d;
      split_pnd_q <= split_pnd_d;
      split_id_q  <= split_id_d;
      split_ovf_q <= split_ovf_d;
      rel_q       <= rel_d;
      turn_cnt_q  <= turn_cnt_d;
    end
  end

  assign grant          = grant_q;
  assign owner_id       = owner_q;
  assign bus_busy       = busy_q;
  assign split_pending  = split_pnd_q;
  assign split_id       = split_id_q;
  assign split_overflow = split_ovf_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench: driver runs a behavioural bus-ownership model and queues expected outputs; monitor compares.
module tb_bus_arbiter;

  localparam int N   = 2;
  localparam int TA  = 1;
  localparam int IDW = $clog2(N);

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic           target_split = 1'b0;
  logic           split_release = 1'b0;
  logic           target_ack = 1'b0;
  logic [N-1:0]   grant;
  logic [IDW-1:0] owner_id;
  logic           bus_busy;
  logic           split_pending;
  logic [IDW-1:0] split_id;
  logic           split_overflow;

  bus_arbiter #(.NUM_INIT(N), .TURNAROUND(TA)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req            (req),
    .target_split   (target_split),
    .split_release  (split_release),
    .target_ack     (target_ack),
    .grant          (grant),
    .owner_id       (owner_id),
    .bus_busy       (bus_busy),
    .split_pending  (split_pending),
    .split_id       (split_id),
    .split_overflow (split_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]   grant;
    logic [IDW-1:0] owner;
    logic           busy;
    logic           pend;
    logic [IDW-1:0] sid;
    logic           ovf;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: who holds the bus, how many idle edges remain, and the split slot.
  int m_grant;    // current holder, -1 when bus is free
  int m_owner;
  bit m_resumed;
  int m_gap;      // edges still to wait before arbitration may happen
  bit m_pend;
  int m_sid;
  bit m_ovf;
  bit m_rel;
  int m_held;

  function automatic void model_reset();
    m_grant = -1; m_owner = N - 1; m_resumed = 0; m_gap = 0;
    m_pend = 0; m_sid = 0; m_ovf = 0; m_rel = 0; m_held = 0;
  endfunction

  function automatic void model_step(input logic [N-1:0] r, input bit ts, input bit sr, input bit ack);
    bit nrel;
    bit drop;
    nrel = m_rel | (sr & m_pend);
    drop = 0;
    if (m_grant >= 0) begin
      if (!m_resumed) begin
        if (ts) begin
          if (!m_pend) begin m_pend = 1; m_sid = m_owner; end
          else m_ovf = 1;
          drop = 1;
        end else if (!r[m_owner]) drop = 1;
      end else begin
        if (ts) m_ovf = 1;
        if (ack) drop = 1;
      end
      if (drop) begin m_grant = -1; m_resumed = 0; m_gap = TA; end
    end else if (m_gap > 0) begin
      m_gap--;
    end else if (m_pend && m_rel) begin
      m_grant = m_sid; m_owner = m_sid; m_resumed = 1; m_pend = 0; nrel = 0;
    end else begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_owner + k) % N;
        if (m_grant < 0 && r[c] && !(m_pend && c == m_sid)) begin
          m_grant = c; m_owner = c;
        end
      end
    end
    m_rel = nrel;
    m_held = (m_grant >= 0 && !drop) ? m_held + 1 : 0;
  endfunction

  function automatic exp_t snap();
    exp_t e;
    e.grant = '0;
    if (m_grant >= 0) e.grant[m_grant] = 1'b1;
    e.owner = IDW'(m_owner);
    e.busy  = (m_grant >= 0);
    e.pend  = m_pend;
    e.sid   = IDW'(m_sid);
    e.ovf   = m_ovf;
    return e;
  endfunction

  task automatic step(input logic [N-1:0] r, input bit ts, input bit sr, input bit ack);
    @(negedge clk);
    #1;
    req = r; target_split = ts; split_release = sr; target_ack = ack;
    model_step(r, ts, sr, ack);
    exp_q.push_back(snap());
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    req = '0; target_split = 0; split_release = 0; target_ack = 0;
    #1;
    n_cmp++;
    if (grant !== '0 || owner_id !== IDW'(N - 1) || bus_busy !== 1'b0 || split_pending !== 1'b0 ||
        split_id !== '0 || split_overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset: got grant=%b owner=%0d busy=%b pend=%b sid=%0d ovf=%b, want 0/%0d/0/0/0/0",
               grant, owner_id, bus_busy, split_pending, split_id, split_overflow, N - 1);
    end
    model_reset();
    exp_q.push_back(snap());
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    model_step('0, 0, 0, 0);
    exp_q.push_back(snap());
  endtask

  task automatic wait_grant(input int idx, input logic [N-1:0] r);
    for (int i = 0; i < 20 && m_grant != idx; i++) step(r, 0, 0, 0);
  endtask

  // Monitor: one expected snapshot per clock edge, compared mid-cycle.
  initial begin
    logic [N-1:0] prev_grant;
    prev_grant = '0;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        n_cmp++;
        if (grant !== e.grant || owner_id !== e.owner || bus_busy !== e.busy ||
            split_pending !== e.pend || (e.pend && split_id !== e.sid) || split_overflow !== e.ovf) begin
          n_bad++;
          $display("FAIL outputs @%0t: got grant=%b owner=%0d busy=%b pend=%b sid=%0d ovf=%b, want grant=%b owner=%0d busy=%b pend=%b sid=%0d ovf=%b",
                   $time, grant, owner_id, bus_busy, split_pending, split_id, split_overflow,
                   e.grant, e.owner, e.busy, e.pend, e.sid, e.ovf);
        end
        if (grant !== prev_grant && grant !== '0)
          $display("txn @%0t: grant=%b owner=%0d split_pending=%b", $time, grant, owner_id, split_pending);
        prev_grant = grant;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    do_reset();

    // Single requester, plus a release pulse with nothing split.
    repeat (3) step(2'b01, 0, 0, 0);
    step(2'b01, 0, 1, 0);
    repeat (4) step(2'b00, 0, 0, 0);

    // Contention: each owner drops after holding for 24 edges.
    for (int c = 0; c < 90; c++) begin
      logic [N-1:0] r;
      r = '1;
      if (m_grant >= 0 && m_held >= 24) r[m_grant] = 1'b0;
      step(r, 0, 0, 0);
    end
    repeat (3) step(2'b00, 0, 0, 0);

    // Split of initiator 0, release during initiator 1's tenure, resume without req[0].
    wait_grant(0, 2'b01);
    step(2'b11, 1, 0, 0);
    wait_grant(1, 2'b10);
    step(2'b10, 0, 1, 0);
    repeat (3) step(2'b10, 0, 0, 0);
    step(2'b00, 0, 0, 0);
    wait_grant(0, 2'b00);
    repeat (3) step(2'b00, 0, 0, 0);
    step(2'b00, 0, 0, 1);
    repeat (3) step(2'b00, 0, 0, 0);

    // Overflow: split initiator 0, then split initiator 1 while slot occupied.
    wait_grant(0, 2'b01);
    step(2'b11, 1, 0, 0);
    wait_grant(1, 2'b10);
    step(2'b10, 1, 0, 0);
    repeat (4) step(2'b10, 0, 0, 0);

    // Reset mid-grant with a split pending, then a fresh request from initiator 1.
    wait_grant(1, 2'b10);
    do_reset();
    repeat (4) step(2'b10, 0, 0, 0);
    step(2'b00, 0, 0, 0);

    // Randomised traffic with rare split/release/ack pulses and one reset in the middle.
    begin
      logic [N-1:0] r;
      r = '0;
      for (int c = 0; c < 800; c++) begin
        for (int b = 0; b < N; b++)
          if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
        if (c == 400) do_reset();
        step(r, $urandom_range(0, 15) == 0, $urandom_range(0, 11) == 0, $urandom_range(0, 5) == 0);
      end
    end

    repeat (3) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d leftover entries, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
